// File: rtl/idu_fwd_stage_pkg.sv
// Shared definitions for the decode/forwarding stage: default widths,
// register index width, decoded-control bundle layout and small
// instruction field helpers.
package idu_fwd_stage_pkg;

  // Default datapath width and forwarding port count
  localparam int XLEN_DEF   = 64;
  localparam int NFWD_DEF   = 3;

  // Architectural register index width (x0..x31)
  localparam int REG_IDX_W  = 5;

  // Default width of the packed decoded-control bundle
  localparam int CTRL_W_DEF = 24;

  // Decoded-control bundle layout, LSB offsets and widths
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W   = 5;
  localparam int CTRL_BR_TYPE_LSB = 5;
  localparam int CTRL_BR_TYPE_W   = 3;
  localparam int CTRL_MEM_OP_LSB = 8;
  localparam int CTRL_MEM_OP_W   = 4;
  localparam int CTRL_WB_SEL_LSB = 12;
  localparam int CTRL_WB_SEL_W   = 2;
  localparam int CTRL_SRC_A_LSB  = 14;
  localparam int CTRL_SRC_A_W    = 2;
  localparam int CTRL_SRC_B_LSB  = 16;
  localparam int CTRL_SRC_B_W    = 2;
  localparam int CTRL_RF_WE_BIT  = 18;
  localparam int CTRL_CSR_LSB    = 19;
  localparam int CTRL_CSR_W      = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Source register 1 index field of a 32-bit instruction
  function automatic reg_idx_t instr_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  // Source register 2 index field of a 32-bit instruction
  function automatic reg_idx_t instr_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  // Destination register index field of a 32-bit instruction
  function automatic reg_idx_t instr_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

endpackage

// File: rtl/idu_fwd_stage_if.sv
// Bus bundle for the decode/forwarding stage: fetch-side handshake and
// payload, regfile read data, forwarding ports, flush and the
// execute-side handshake and registered payload.
interface idu_fwd_stage_if
  import idu_fwd_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NFWD   = NFWD_DEF,
  parameter int CTRL_W = CTRL_W_DEF
);

  // Fetch side
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_instr;
  logic [XLEN-1:0]           in_pc;
  logic [XLEN-1:0]           in_snxt_pc;
  logic [CTRL_W-1:0]         in_ctrl;
  logic [XLEN-1:0]           in_imm;
  logic                      in_need_rs1;
  logic                      in_need_rs2;

  // Regfile read data
  logic [XLEN-1:0]           rf_rs1_data;
  logic [XLEN-1:0]           rf_rs2_data;

  // Forwarding ports, port 0 youngest
  logic [NFWD-1:0]           fwd_en;
  logic [NFWD-1:0]           fwd_busy;
  logic [NFWD*REG_IDX_W-1:0] fwd_rd;
  logic [NFWD*XLEN-1:0]      fwd_data;

  logic                      flush;
  logic                      hazard_stall;

  // Execute side
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_instr;
  logic [XLEN-1:0]           out_pc;
  logic [XLEN-1:0]           out_snxt_pc;
  logic [CTRL_W-1:0]         out_ctrl;
  logic [XLEN-1:0]           out_imm;
  logic [XLEN-1:0]           out_rs1_data;
  logic [XLEN-1:0]           out_rs2_data;
  logic [REG_IDX_W-1:0]      out_rs1_idx;
  logic [REG_IDX_W-1:0]      out_rs2_idx;
  logic [REG_IDX_W-1:0]      out_rd_idx;

  // The stage itself
  modport slave (
    input  in_valid, in_instr, in_pc, in_snxt_pc, in_ctrl, in_imm,
           in_need_rs1, in_need_rs2, rf_rs1_data, rf_rs2_data,
           fwd_en, fwd_busy, fwd_rd, fwd_data, flush, out_ready,
    output in_ready, hazard_stall, out_valid, out_instr, out_pc,
           out_snxt_pc, out_ctrl, out_imm, out_rs1_data, out_rs2_data,
           out_rs1_idx, out_rs2_idx, out_rd_idx
  );

  // The surrounding pipeline (fetch, regfile, producers, execute)
  modport master (
    output in_valid, in_instr, in_pc, in_snxt_pc, in_ctrl, in_imm,
           in_need_rs1, in_need_rs2, rf_rs1_data, rf_rs2_data,
           fwd_en, fwd_busy, fwd_rd, fwd_data, flush, out_ready,
    input  in_ready, hazard_stall, out_valid, out_instr, out_pc,
           out_snxt_pc, out_ctrl, out_imm, out_rs1_data, out_rs2_data,
           out_rs1_idx, out_rs2_idx, out_rd_idx
  );

endinterface

// File: rtl/idu_fwd_mux.sv
// Operand forwarding resolution for one source operand. The lowest
// numbered matching port wins; x0 never matches and always reads zero.
module idu_fwd_mux
  import idu_fwd_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NFWD = NFWD_DEF
) (
  input  reg_idx_t                  idx_i,
  input  logic [XLEN-1:0]           rf_data_i,
  input  logic [NFWD-1:0]           fwd_en_i,
  input  logic [NFWD-1:0]           fwd_busy_i,
  input  logic [NFWD*REG_IDX_W-1:0] fwd_rd_i,
  input  logic [NFWD*XLEN-1:0]      fwd_data_i,
  output logic [XLEN-1:0]           data_o,
  output logic                      busy_o
);

  // Walk from the oldest port to the youngest so the youngest match overrides
  always_comb begin
    data_o = (idx_i == '0) ? '0 : rf_data_i;
    busy_o = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_en_i[i] && (idx_i != '0) &&
          (fwd_rd_i[i*REG_IDX_W +: REG_IDX_W] == idx_i)) begin
        data_o = fwd_data_i[i*XLEN +: XLEN];
        busy_o = fwd_busy_i[i];
      end
    end
  end

endmodule

// File: rtl/idu_fwd_stage.sv
// Decode/forwarding pipeline stage: resolves both source operands against
// the forwarding ports, stalls on in-flight loads and registers the whole
// instruction bundle toward execute.
// Optional macro IDU_FWD_SKID_EN adds a one-entry skid buffer so in_ready
// no longer depends combinationally on out_ready.
module idu_fwd_stage
  import idu_fwd_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NFWD   = NFWD_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  idu_fwd_stage_if.slave   bus
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   snxt_pc;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    reg_idx_t          rs1_idx;
    reg_idx_t          rs2_idx;
    reg_idx_t          rd_idx;
  } payload_t;

  reg_idx_t        rs1_idx;
  reg_idx_t        rs2_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            hazard_stall;
  logic            in_ready;
  logic            transfer;
  payload_t        in_payload;

  logic            out_valid_q;
  logic            out_valid_d;
  payload_t        out_q;
  payload_t        out_d;

  assign rs1_idx = instr_rs1(bus.in_instr);
  assign rs2_idx = instr_rs2(bus.in_instr);

  idu_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_rs1_mux (
    .idx_i      (rs1_idx),
    .rf_data_i  (bus.rf_rs1_data),
    .fwd_en_i   (bus.fwd_en),
    .fwd_busy_i (bus.fwd_busy),
    .fwd_rd_i   (bus.fwd_rd),
    .fwd_data_i (bus.fwd_data),
    .data_o     (rs1_val),
    .busy_o     (rs1_busy)
  );

  idu_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_rs2_mux (
    .idx_i      (rs2_idx),
    .rf_data_i  (bus.rf_rs2_data),
    .fwd_en_i   (bus.fwd_en),
    .fwd_busy_i (bus.fwd_busy),
    .fwd_rd_i   (bus.fwd_rd),
    .fwd_data_i (bus.fwd_data),
    .data_o     (rs2_val),
    .busy_o     (rs2_busy)
  );

  // A needed operand whose winning producer is still busy blocks acceptance
  assign hazard_stall = bus.in_valid &
                        ((bus.in_need_rs1 & rs1_busy) | (bus.in_need_rs2 & rs2_busy));

  assign transfer = bus.in_valid & in_ready;

  // Bundle the incoming fields together with the resolved operands
  always_comb begin
    in_payload          = '0;
    in_payload.instr    = bus.in_instr;
    in_payload.pc       = bus.in_pc;
    in_payload.snxt_pc  = bus.in_snxt_pc;
    in_payload.ctrl     = bus.in_ctrl;
    in_payload.imm      = bus.in_imm;
    in_payload.rs1_data = rs1_val;
    in_payload.rs2_data = rs2_val;
    in_payload.rs1_idx  = rs1_idx;
    in_payload.rs2_idx  = rs2_idx;
    in_payload.rd_idx   = instr_rd(bus.in_instr);
  end

`ifdef IDU_FWD_SKID_EN

  logic     skid_valid_q;
  logic     skid_valid_d;
  payload_t skid_q;
  payload_t skid_d;

  // Ready only looks at registered skid occupancy, breaking the out_ready path
  assign in_ready = ~skid_valid_q & ~hazard_stall;

  // Output slot refills from skid first, then from the input; a stalled output diverts into skid
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (transfer) begin
        out_d       = in_payload;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (transfer) begin
      skid_d       = in_payload;
      skid_valid_d = 1'b1;
    end
  end

  // Skid storage, cleared immediately on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

`else

  // Accept whenever the output slot is free or being drained this cycle
  assign in_ready = (~out_valid_q | bus.out_ready) & ~hazard_stall;

  // Single output slot: flush kills it, a transfer loads it, a drain empties it
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (transfer) begin
      out_d       = in_payload;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`endif

  // Output register, cleared immediately on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.hazard_stall = hazard_stall;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = out_q.instr;
  assign bus.out_pc       = out_q.pc;
  assign bus.out_snxt_pc  = out_q.snxt_pc;
  assign bus.out_ctrl     = out_q.ctrl;
  assign bus.out_imm      = out_q.imm;
  assign bus.out_rs1_data = out_q.rs1_data;
  assign bus.out_rs2_data = out_q.rs2_data;
  assign bus.out_rs1_idx  = out_q.rs1_idx;
  assign bus.out_rs2_idx  = out_q.rs2_idx;
  assign bus.out_rd_idx   = out_q.rd_idx;

endmodule

// File: tb/tb_idu_fwd_stage.sv
// Self-checking bench for idu_fwd_stage. Works with or without
// IDU_FWD_SKID_EN defined; a scoreboard queue holds the expected output
// bundles, pushed at acceptance and popped when execute consumes one.
module tb_idu_fwd_stage;
   import idu_fwd_stage_pkg::*;

   localparam int XLEN   = 64;
   localparam int NFWD   = 3;
   localparam int CTRL_W = 24;
`ifdef IDU_FWD_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct packed {
      logic [31:0]       instr;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   snxtPc;
      logic [CTRL_W-1:0] ctrl;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   rs1Data;
      logic [XLEN-1:0]   rs2Data;
      logic [4:0]        rs1Idx;
      logic [4:0]        rs2Idx;
      logic [4:0]        rdIdx;
   } bundle_t;

   logic clk;
   logic rstn;
   int   checkCount = 0;
   int   passCount  = 0;
   int   cycleCount = 0;
   int   outFireCount = 0;
   bundle_t sb[$];
   logic [XLEN-1:0] outPcLog[$];

   idu_fwd_stage_if #(.XLEN(XLEN), .NFWD(NFWD), .CTRL_W(CTRL_W)) bus ();

   idu_fwd_stage #(.XLEN(XLEN), .NFWD(NFWD), .CTRL_W(CTRL_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter for throughput measurement
   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checkCount = checkCount + 1;
      assert (obs === exp) passCount = passCount + 1;
      else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mkInstr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   // Reference operand resolution: scan from the youngest port, first match wins
   function automatic logic [XLEN:0] resolveOperand(input logic [4:0] idx, input logic [XLEN-1:0] rf);
      if (idx == 5'd0) return '0;
      for (int i = 0; i < NFWD; i++) begin
         if (bus.fwd_en[i] && bus.fwd_rd[i*5 +: 5] == idx)
            return {bus.fwd_busy[i], bus.fwd_data[i*XLEN +: XLEN]};
      end
      return {1'b0, rf};
   endfunction

   function automatic bundle_t observedBundle();
      return {bus.out_instr, bus.out_pc, bus.out_snxt_pc, bus.out_ctrl, bus.out_imm,
              bus.out_rs1_data, bus.out_rs2_data, bus.out_rs1_idx, bus.out_rs2_idx, bus.out_rd_idx};
   endfunction

   // Scoreboard monitor: checks handshake outputs against the model and tracks queued bundles
   always @(negedge clk) begin : monitor
      logic [XLEN:0] r1;
      logic [XLEN:0] r2;
      logic          hzExp;
      logic          readyExp;
      bundle_t       e;
      bundle_t       got;
      if (!rstn) begin
         sb.delete();
      end else begin
         r1 = resolveOperand(bus.in_instr[19:15], bus.rf_rs1_data);
         r2 = resolveOperand(bus.in_instr[24:20], bus.rf_rs2_data);
         hzExp = bus.in_valid & ((bus.in_need_rs1 & r1[XLEN]) | (bus.in_need_rs2 & r2[XLEN]));
         if (SKID) readyExp = (sb.size() < 2) & ~hzExp;
         else      readyExp = ((sb.size() == 0) | bus.out_ready) & ~hzExp;
         checkOutput("hazard_stall", bus.hazard_stall, hzExp);
         checkOutput("in_ready", bus.in_ready, readyExp);
         checkOutput("out_valid", bus.out_valid, sb.size() != 0);
         if (bus.flush) begin
            sb.delete();
         end else begin
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
               e   = sb.pop_front();
               got = observedBundle();
               checkOutput("out_rs1_data", got.rs1Data, e.rs1Data);
               checkOutput("out_rs2_data", got.rs2Data, e.rs2Data);
               checkOutput("out_bundle", got, e);
               outPcLog.push_back(bus.out_pc);
               outFireCount = outFireCount + 1;
            end
            if (bus.in_valid && readyExp) begin
               e.instr   = bus.in_instr;
               e.pc      = bus.in_pc;
               e.snxtPc  = bus.in_snxt_pc;
               e.ctrl    = bus.in_ctrl;
               e.imm     = bus.in_imm;
               e.rs1Data = r1[XLEN-1:0];
               e.rs2Data = r2[XLEN-1:0];
               e.rs1Idx  = bus.in_instr[19:15];
               e.rs2Idx  = bus.in_instr[24:20];
               e.rdIdx   = bus.in_instr[11:7];
               sb.push_back(e);
            end
         end
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic setFields(input logic [XLEN-1:0] pc, input logic [31:0] instr,
                            input logic need1, input logic need2);
      bus.in_instr    = instr;
      bus.in_pc       = pc;
      bus.in_snxt_pc  = pc + 64'd4;
      bus.in_ctrl     = pc[23:0] ^ 24'hA5A5A5;
      bus.in_imm      = {32'hFFFF_0000, instr};
      bus.in_need_rs1 = need1;
      bus.in_need_rs2 = need2;
      bus.rf_rs1_data = 64'hF100_0000_0000_0000 | pc;
      bus.rf_rs2_data = 64'hE200_0000_0000_0000 | pc;
   endtask

   // Present one instruction and hold it until the stage accepts it (bounded)
   task automatic applyStimulus(input logic [XLEN-1:0] pc, input logic [31:0] instr,
                                input logic need1, input logic need2);
      bit accepted;
      accepted = 1'b0;
      setFields(pc, instr, need1, need2);
      bus.in_valid = 1'b1;
      for (int n = 0; n < 40 && !accepted; n++) begin
         @(negedge clk);
         if (bus.in_ready) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      checkOutput("accepted", accepted, 1'b1);
   endtask

   initial begin
      int base;
      int startCycle;
      rstn = 1'b0;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.in_snxt_pc = '0;
      bus.in_ctrl = '0; bus.in_imm = '0; bus.in_need_rs1 = 1'b0; bus.in_need_rs2 = 1'b0;
      bus.rf_rs1_data = '0; bus.rf_rs2_data = '0; bus.fwd_en = '0; bus.fwd_busy = '0;
      bus.fwd_rd = '0; bus.fwd_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;

      // Reset state
      repeat (2) stepCycle();
      checkOutput("reset_out_valid", bus.out_valid, 1'b0);
      checkOutput("reset_out_pc", bus.out_pc, 64'd0);
      checkOutput("reset_out_rs1_data", bus.out_rs1_data, 64'd0);
      checkOutput("reset_in_ready", bus.in_ready, 1'b1);
      rstn = 1'b1;
      stepCycle();

      // Forwarding priority: all three ports match, youngest wins; x0 reads zero
      bus.fwd_en   = 3'b111;
      bus.fwd_rd   = {5'd5, 5'd5, 5'd5};
      bus.fwd_data = {64'hC, 64'hB, 64'hA};
      applyStimulus(64'h100, mkInstr(5'd1, 5'd5, 5'd0), 1'b1, 1'b1);
      checkOutput("prio_rs1_port0", bus.out_rs1_data, 64'hA);
      checkOutput("prio_rs2_x0", bus.out_rs2_data, 64'h0);
      bus.fwd_en = 3'b110;
      applyStimulus(64'h104, mkInstr(5'd2, 5'd5, 5'd6), 1'b1, 1'b1);
      checkOutput("prio_rs1_port1", bus.out_rs1_data, 64'hB);
      checkOutput("nomatch_rs2_rf", bus.out_rs2_data, 64'hE200_0000_0000_0104);
      bus.fwd_en   = 3'b101;
      bus.fwd_rd   = {5'd9, 5'd5, 5'd0};
      bus.fwd_data = {64'hC, 64'hB, 64'h55};
      applyStimulus(64'h108, mkInstr(5'd3, 5'd9, 5'd0), 1'b1, 1'b1);
      checkOutput("prio_rs1_port2", bus.out_rs1_data, 64'hC);
      checkOutput("rd0_x0_rs2", bus.out_rs2_data, 64'h0);
      bus.in_valid = 1'b0;
      bus.fwd_en = '0;
      stepCycle();

      // Load-use: port 1 writes x7 but its result is busy for two cycles
      bus.fwd_en   = 3'b010;
      bus.fwd_busy = 3'b010;
      bus.fwd_rd   = {5'd0, 5'd7, 5'd0};
      bus.fwd_data = {64'h0, 64'h777, 64'h0};
      setFields(64'h200, mkInstr(5'd4, 5'd1, 5'd7), 1'b1, 1'b1);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checkOutput("loaduse_hazard", bus.hazard_stall, 1'b1);
         checkOutput("loaduse_in_ready", bus.in_ready, 1'b0);
         stepCycle();
      end
      bus.fwd_busy = 3'b000;
      applyStimulus(64'h200, mkInstr(5'd4, 5'd1, 5'd7), 1'b1, 1'b1);
      checkOutput("loaduse_rs2_fwd", bus.out_rs2_data, 64'h777);
      // Busy match on an operand that is not needed must not stall
      bus.fwd_busy = 3'b010;
      setFields(64'h204, mkInstr(5'd4, 5'd1, 5'd7), 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("unneeded_no_hazard", bus.hazard_stall, 1'b0);
      stepCycle();
      bus.in_valid = 1'b0;
      bus.fwd_en = '0;
      bus.fwd_busy = '0;
      stepCycle();

      // Backpressure: output stalled for two cycles while three instructions stream
      base = outPcLog.size();
      bus.out_ready = 1'b0;
      setFields(64'h8000_0000, mkInstr(5'd1, 5'd2, 5'd3), 1'b1, 1'b1);
      bus.in_valid = 1'b1;
      @(negedge clk);
      checkOutput("bp_ready_first", bus.in_ready, 1'b1);
      stepCycle();
      setFields(64'h8000_0004, mkInstr(5'd2, 5'd3, 5'd4), 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("bp_ready_second", bus.in_ready, SKID);
      stepCycle();
`ifdef IDU_FWD_SKID_EN
      setFields(64'h8000_0008, mkInstr(5'd3, 5'd4, 5'd5), 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("bp_ready_skid_full", bus.in_ready, 1'b0);
      stepCycle();
      bus.out_ready = 1'b1;
      applyStimulus(64'h8000_0008, mkInstr(5'd3, 5'd4, 5'd5), 1'b1, 1'b1);
`else
      bus.out_ready = 1'b1;
      applyStimulus(64'h8000_0004, mkInstr(5'd2, 5'd3, 5'd4), 1'b1, 1'b1);
      applyStimulus(64'h8000_0008, mkInstr(5'd3, 5'd4, 5'd5), 1'b1, 1'b1);
`endif
      bus.in_valid = 1'b0;
      repeat (3) stepCycle();
      checkOutput("bp_count", outPcLog.size() - base, 3);
      if (outPcLog.size() >= base + 3) begin
         checkOutput("bp_order0", outPcLog[base],     64'h8000_0000);
         checkOutput("bp_order1", outPcLog[base + 1], 64'h8000_0004);
         checkOutput("bp_order2", outPcLog[base + 2], 64'h8000_0008);
      end

      // Flush colliding with a transfer into an empty stage
      setFields(64'h300, mkInstr(5'd1, 5'd1, 5'd1), 1'b1, 1'b1);
      bus.in_valid = 1'b1;
      bus.flush = 1'b1;
      stepCycle();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      checkOutput("flush_empty_out_valid", bus.out_valid, 1'b0);
      stepCycle();

      // Flush with a stalled output (and full skid when present)
      bus.out_ready = 1'b0;
      applyStimulus(64'h400, mkInstr(5'd1, 5'd2, 5'd3), 1'b1, 1'b1);
      if (SKID) applyStimulus(64'h404, mkInstr(5'd2, 5'd3, 5'd4), 1'b1, 1'b1);
      setFields(64'h408, mkInstr(5'd3, 5'd4, 5'd5), 1'b1, 1'b1);
      bus.flush = 1'b1;
      stepCycle();
      bus.flush = 1'b0;
      checkOutput("flush_out_valid", bus.out_valid, 1'b0);
      @(negedge clk);
      checkOutput("flush_in_ready", bus.in_ready, 1'b1);
      stepCycle();
      checkOutput("post_flush_out_valid", bus.out_valid, 1'b1);
      checkOutput("post_flush_out_pc", bus.out_pc, 64'h408);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      stepCycle();

      // Reset asserted while an output is held under backpressure
      bus.out_ready = 1'b0;
      applyStimulus(64'h500, mkInstr(5'd1, 5'd3, 5'd4), 1'b1, 1'b1);
      bus.in_valid = 1'b0;
      checkOutput("hold_out_valid", bus.out_valid, 1'b1);
      rstn = 1'b0;
      #2;
      checkOutput("async_rst_out_valid", bus.out_valid, 1'b0);
      checkOutput("async_rst_rs1_data", bus.out_rs1_data, 64'd0);
      checkOutput("async_rst_in_ready", bus.in_ready, 1'b1);
      stepCycle();
      rstn = 1'b1;
      bus.out_ready = 1'b1;
      stepCycle();

      // Throughput: sixteen back-to-back instructions, one per cycle, latency one
      base = outFireCount;
      startCycle = cycleCount;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(64'h1000 + 64'(4 * i), mkInstr(5'(i), 5'(i + 1), 5'(i + 2)), 1'b1, 1'b1);
         checkOutput("tput_out_pc", bus.out_pc, 64'h1000 + 64'(4 * i));
      end
      checkOutput("tput_cycles", cycleCount - startCycle, 16);
      bus.in_valid = 1'b0;
      repeat (2) stepCycle();
      checkOutput("tput_fires", outFireCount - base, 16);
      checkOutput("drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/idu_fwd_stage.md
IDU_FWD_STAGE -- requirements
Module: idu_fwd_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, the datapath width.
REQ-002 SHALL have parameter NFWD, default 3, the number of forwarding ports; port 0 is the youngest producer and has the highest priority.
REQ-003 SHALL have parameter CTRL_W, default 24, the width of the packed decoded-control bundle.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-007 in_instr  in  32  instruction; in_pc, in_snxt_pc  in  XLEN  PC and static next PC.
REQ-008 in_ctrl  in  CTRL_W  decoded controls; in_imm  in  XLEN  immediate; in_need_rs1, in_need_rs2  in  1  operand-use flags.
REQ-009 rf_rs1_data, rf_rs2_data  in  XLEN  regfile read data for in_instr[19:15] and in_instr[24:20].
REQ-010 fwd_en  in  NFWD  port writes a register; fwd_busy  in  NFWD  result not yet available (load in flight).
REQ-011 fwd_rd  in  NFWD*5  destination index per port; fwd_data  in  NFWD*XLEN  result per port.
REQ-012 flush  in  1  kill all held and incoming instructions.
REQ-013 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-014 Registered copies of every input field SHALL be presented as out_instr, out_pc, out_snxt_pc, out_ctrl, out_imm, out_rs1_data, out_rs2_data, out_rs1_idx, out_rs2_idx, out_rd_idx.
REQ-015 hazard_stall  out  1  combinational; high while a busy match blocks acceptance.

Function
REQ-016 The forwarding match for operand k SHALL require fwd_en[i], fwd_rd[i] equal to the operand index, and fwd_rd[i] not equal to 0.
REQ-017 The lowest-index matching port SHALL supply the operand; with no match, the regfile data SHALL be used; index x0 SHALL always read 0.
REQ-018 hazard_stall SHALL assert when in_valid is high and a needed operand's highest-priority match has fwd_busy set.
REQ-019 in_ready SHALL be low while hazard_stall is high.
REQ-020 A transfer SHALL occur when in_valid and in_ready are both high; it SHALL capture all fields and the resolved operands in the same cycle, giving a latency of 1 cycle.
REQ-021 Without skid, in_ready SHALL equal (!out_valid | out_ready) & !hazard_stall.
REQ-022 While out_valid is high and out_ready is low, all out_* signals SHALL hold stable.
REQ-023 flush SHALL take priority over everything: next cycle out_valid = 0, skid empty, in_ready unaffected by the flushed entry, and no transfer counted.
REQ-024 If flush and a transfer occur simultaneously, the incoming instruction SHALL be discarded.
REQ-025 Back-to-back transfers SHALL sustain 1 instruction per cycle when out_ready is held high.

Reset
REQ-026 On rstn low, the block SHALL immediately clear out_valid, skid valid and every out_* data/control register to 0, whether or not a transfer is in progress.
REQ-027 in_ready SHALL be 1 during reset release unless hazard_stall is high.

Configuration
REQ-028 Macro IDU_FWD_SKID_EN SHALL select the skid feature.
REQ-029 With IDU_FWD_SKID_EN defined: a one-entry skid buffer SHALL be present; in_ready = !skid_valid & !hazard_stall (registered, no out_ready path); a transfer arriving while output is stalled SHALL land in skid; when skid drains, skid SHALL move to output.
REQ-030 With IDU_FWD_SKID_EN defined: ordering SHALL be preserved and no entry SHALL be lost or duplicated.
REQ-031 Without IDU_FWD_SKID_EN: no skid storage SHALL exist, and REQ-021 applies.

Structure
REQ-032 A shared package SHALL hold XLEN default, the register index width (5), the CTRL_W default, and the ctrl bundle field offsets.
REQ-033 Forwarding resolution SHALL be one sub-module, idu_fwd_mux, instantiated once per operand.

Verification
REQ-034 Reset mid-hold: out_valid=1 stalled, rstn pulsed low -> out_valid=0 and out_rs1_data=0 asynchronously, before the next edge.
REQ-035 Priority: rs1=5, fwd_en=3'b111, fwd_rd={5,5,5}, data {0xA,0xB,0xC} on ports 0/1/2 -> out_rs1_data=0xA; rs2=0, fwd_rd=0, data 0x55 -> out_rs2_data=0.
REQ-036 Load-use: rs2=7, in_need_rs2=1, port 1 rd=7 busy for 2 cycles -> hazard_stall=1 and in_ready=0 for 2 cycles, then accept with port 1 data.
REQ-037 Backpressure (skid on): 3 instructions streamed, out_ready low 2 cycles -> in_ready drops after 1 extra accept; all 3 emerge in order with PCs 0x80000000/04/08.
REQ-038 Flush collision: flush=1 with in_valid=1 and a stalled output -> next cycle out_valid=0, skid empty, following instruction accepted normally.
REQ-039 Throughput: 16 instructions with out_ready=1 -> 16 transfers in 16 consecutive cycles, latency 1 each.
